mem_switch_arbiter: RTL and testbench
=====================================

MEM_SWITCH_ARBITER -- requirements
Module: mem_switch_arbiter

Interface
REQ-001 SHALL have parameter SWITCH_ADDR, default 22'h2400, address of the read-only switch-board info word.
REQ-002 SHALL have parameter INFO_RESET, default 32'hab, reset value of the switch-board info word.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 A_req  input  1  CPU A request; held with A_addr, A_we and A_write_data until A_ack.
REQ-006 A_addr  input  22  CPU A word address.
REQ-007 A_we  input  1  CPU A write (1) / read (0).
REQ-008 A_write_data  input  32  CPU A write data.
REQ-009 A_ack  output  1  one-cycle completion pulse for CPU A.
REQ-010 A_err  output  1  valid with A_ack; 1 = access rejected.
REQ-011 A_read_data  output  32  CPU A read result; valid with A_ack, held until the next A_ack.
REQ-012 B_req, B_addr, B_we, B_write_data, B_ack, B_err, B_read_data SHALL mirror REQ-005..011 for CPU B.
REQ-013 info_load  input  1  loads info_data into the switch-board word.
REQ-014 info_data  input  32  new switch-board value.
REQ-015 mem_addr  output  10  single-port synchronous RAM address.
REQ-016 mem_we  output  1  RAM write enable.
REQ-017 mem_din  output  32  RAM write data.
REQ-018 mem_dout  input  32  RAM read data, valid one clk after the address is presented.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when a request is accepted; ACCESS->RESP and RESP->IDLE unconditionally.
REQ-020 In IDLE, eligible request = req high and the same port's ack low in that cycle; a port whose ack is high is masked for that cycle.
REQ-021 Single eligible request SHALL be granted; two eligible requests SHALL be granted to the port not granted last (round-robin); last_grant resets to B, so A wins the first collision.
REQ-022 On grant, SHALL register the granted port's addr[9:0] into mem_addr and its write_data into mem_din, and classify the access.
REQ-023 Classes: A write in 22'h2000..22'h21ff, or B write in 22'h2200..22'h23ff = MEM_WR; any read in 22'h2000..22'h23ff = MEM_RD; read at SWITCH_ADDR = INFO_RD; all else (foreign-window write, write to SWITCH_ADDR, out-of-range address) = REJECT.
REQ-024 mem_we SHALL be 1 only during the ACCESS cycle of a MEM_WR, otherwise 0.
REQ-025 At the RESP->IDLE edge SHALL set the granted port's ack=1 for exactly one cycle, with err=1 for REJECT and 0 otherwise.
REQ-026 At the same edge SHALL load read_data: mem_dout for MEM_RD, the switch-board word for INFO_RD, 32'h0 for REJECT; read_data SHALL be unchanged for MEM_WR.
REQ-027 Latency: req accepted in IDLE cycle n -> ACCESS n+1 -> RESP n+2 -> ack high in cycle n+3; the next grant is possible in cycle n+3.
REQ-028 The non-granted port's ack, err and read_data SHALL be unchanged.
REQ-029 info_load SHALL update the switch-board word at the next edge in any state; an INFO_RD whose RESP edge coincides with info_load SHALL return the old value.
REQ-030 A req that is still high in the cycle after its own ack SHALL be treated as a new request.

Reset
REQ-031 On rst SHALL immediately force: state IDLE, mem_we=0, mem_addr=0, mem_din=0, A_ack=B_ack=0, A_err=B_err=0, A_read_data=B_read_data=0, last_grant=B, switch-board word=INFO_RESET.
REQ-032 rst during ACCESS or RESP SHALL abort the transaction with no ack; requests still high after rst deasserts SHALL re-arbitrate from IDLE.

Verification
REQ-033 A write 22'h2005 data 32'h12345678, then A read 22'h2005 -> mem_we pulses with mem_addr=10'h005; read ack in cycle n+3 with A_read_data=32'h12345678, A_err=0.
REQ-034 A_req and B_req rise together, both reads -> A acked first, then B acked 3 cycles later; a second collision -> B granted first.
REQ-035 B write to 22'h2010 (A window) -> B_ack with B_err=1, mem_we stays 0, B_read_data=0.
REQ-036 After reset, A read of 22'h2400 -> 32'hab; pulse info_load with info_data 32'hc0de, B read of 22'h2400 -> 32'hc0de.
REQ-037 rst asserted during ACCESS of an A write -> mem_we drops at once and no A_ack; after release with A_req still high -> normal write and ack.
REQ-038 A holds A_req high continuously while B requests -> grants alternate A, B, A, with no B starvation.

Source files
------------

// File: rtl/mem_switch_arbiter.sv
// Two-CPU arbiter onto a single-port synchronous RAM with a read-only switch-board
// info word. Round-robin on collisions, one access in flight, fixed 3-cycle response.
`timescale 1ns/1ps
module mem_switch_arbiter #(
  parameter logic [21:0] SWITCH_ADDR = 22'h2400,
  parameter logic [31:0] INFO_RESET  = 32'hab
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        A_req,
  input  logic [21:0] A_addr,
  input  logic        A_we,
  input  logic [31:0] A_write_data,
  output logic        A_ack,
  output logic        A_err,
  output logic [31:0] A_read_data,
  input  logic        B_req,
  input  logic [21:0] B_addr,
  input  logic        B_we,
  input  logic [31:0] B_write_data,
  output logic        B_ack,
  output logic        B_err,
  output logic [31:0] B_read_data,
  input  logic        info_load,
  input  logic [31:0] info_data,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [1:0]  dbg_state
);

  // Handshake: a CPU raises req with addr/we/write_data stable and holds them until
  // its one-cycle ack; err/read_data are valid with ack, and a req still high the
  // cycle after ack is a fresh request.

  localparam logic [21:0] WIN_LO = 22'h2000;
  localparam logic [21:0] A_HI   = 22'h21ff;
  localparam logic [21:0] B_LO   = 22'h2200;
  localparam logic [21:0] WIN_HI = 22'h23ff;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {MEM_WR, MEM_RD, INFO_RD, REJECT} cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic        gnt_b_q, gnt_b_d;
  logic        last_b_q, last_b_d;
  logic [9:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        mem_we_q, mem_we_d;
  logic        a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic        b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [31:0] a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic [31:0] info_q, info_d;

  logic        a_elig, b_elig, pick_b;
  logic        resp_err;
  logic [31:0] resp_data;

  // Each CPU may only write its own half of the shared window; reads span both.
  function automatic cls_t classify(input logic [21:0] addr, input logic we,
                                    input logic from_b);
    logic in_win;
    logic own_win;
    in_win  = (addr >= WIN_LO) && (addr <= WIN_HI);
    own_win = from_b ? ((addr >= B_LO) && (addr <= WIN_HI))
                     : ((addr >= WIN_LO) && (addr <= A_HI));
    if (we)                       classify = own_win ? MEM_WR : REJECT;
    else if (in_win)              classify = MEM_RD;
    else if (addr == SWITCH_ADDR) classify = INFO_RD;
    else                          classify = REJECT;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cls_q      <= REJECT;
      gnt_b_q    <= 1'b0;
      last_b_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      a_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      a_rd_q     <= '0;
      b_ack_q    <= 1'b0;
      b_err_q    <= 1'b0;
      b_rd_q     <= '0;
      info_q     <= INFO_RESET;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      gnt_b_q    <= gnt_b_d;
      last_b_q   <= last_b_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      a_ack_q    <= a_ack_d;
      a_err_q    <= a_err_d;
      a_rd_q     <= a_rd_d;
      b_ack_q    <= b_ack_d;
      b_err_q    <= b_err_d;
      b_rd_q     <= b_rd_d;
      info_q     <= info_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    gnt_b_d    = gnt_b_q;
    last_b_d   = last_b_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    a_ack_d    = 1'b0;
    a_err_d    = a_err_q;
    a_rd_d     = a_rd_q;
    b_ack_d    = 1'b0;
    b_err_d    = b_err_q;
    b_rd_d     = b_rd_q;
    info_d     = info_load ? info_data : info_q;

    // A port being acked this cycle is masked so a held req is not double-served.
    a_elig = A_req & ~a_ack_q;
    b_elig = B_req & ~b_ack_q;
    pick_b = b_elig & (~a_elig | ~last_b_q);

    resp_err = (cls_q == REJECT);
    case (cls_q)
      MEM_RD:  resp_data = mem_dout;
      INFO_RD: resp_data = info_q;
      default: resp_data = 32'h0;
    endcase

    case (state_q)
      IDLE: begin
        if (a_elig | b_elig) begin
          state_d    = ACCESS;
          gnt_b_d    = pick_b;
          last_b_d   = pick_b;
          mem_addr_d = pick_b ? B_addr[9:0] : A_addr[9:0];
          mem_din_d  = pick_b ? B_write_data : A_write_data;
          cls_d      = classify(pick_b ? B_addr : A_addr, pick_b ? B_we : A_we, pick_b);
          mem_we_d   = (cls_d == MEM_WR);
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (gnt_b_q) begin
          b_ack_d = 1'b1;
          b_err_d = resp_err;
          if (cls_q != MEM_WR) b_rd_d = resp_data;
        end else begin
          a_ack_d = 1'b1;
          a_err_d = resp_err;
          if (cls_q != MEM_WR) a_rd_d = resp_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign A_ack       = a_ack_q;
  assign A_err       = a_err_q;
  assign A_read_data = a_rd_q;
  assign B_ack       = b_ack_q;
  assign B_err       = b_err_q;
  assign B_read_data = b_rd_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_din     = mem_din_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_switch_arbiter.sv
// Bench for mem_switch_arbiter: vector table, directed multi-cycle sequences and
// randomized two-CPU traffic scored against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_switch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        A_req, A_we, A_ack, A_err;
  logic [21:0] A_addr;
  logic [31:0] A_write_data, A_read_data;
  logic        B_req, B_we, B_ack, B_err;
  logic [21:0] B_addr;
  logic [31:0] B_write_data, B_read_data;
  logic        info_load;
  logic [31:0] info_data;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_switch_arbiter dut (
    .clk(clk), .rst(rst),
    .A_req(A_req), .A_addr(A_addr), .A_we(A_we), .A_write_data(A_write_data),
    .A_ack(A_ack), .A_err(A_err), .A_read_data(A_read_data),
    .B_req(B_req), .B_addr(B_addr), .B_we(B_we), .B_write_data(B_write_data),
    .B_ack(B_ack), .B_err(B_err), .B_read_data(B_read_data),
    .info_load(info_load), .info_data(info_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .dbg_state(dbg_state)
  );

  // clock / reset / memory environment
  always #5 clk = ~clk;

  logic [31:0] ram [1024] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_port(input bit p, input bit req, input bit we,
                          input logic [21:0] addr, input logic [31:0] wd);
    if (p) begin
      B_req = req; B_we = we; B_addr = addr; B_write_data = wd;
    end else begin
      A_req = req; A_we = we; A_addr = addr; A_write_data = wd;
    end
  endtask

  task automatic do_txn(input bit p, input bit we, input logic [21:0] addr,
                        input logic [31:0] wd, output int lat, output bit err,
                        output logic [31:0] rd, output bit saw_we,
                        output logic [9:0] we_addr, output bit other_ack);
    lat = -1; err = 1'b0; rd = '0; saw_we = 1'b0; we_addr = '0; other_ack = 1'b0;
    set_port(p, 1'b1, we, addr, wd);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mem_we) begin saw_we = 1'b1; we_addr = mem_addr; end
      if (p ? A_ack : B_ack) other_ack = 1'b1;
      if (p ? B_ack : A_ack) begin
        lat = i;
        err = p ? B_err : A_err;
        rd  = p ? B_read_data : A_read_data;
        break;
      end
    end
    set_port(p, 1'b0, we, addr, wd);
  endtask

  int ack_port [8];
  int ack_cyc  [8];
  int ack_n;

  task automatic run_both(input bit hold, input int n_acks);
    ack_n = 0;
    A_req = 1'b1; B_req = 1'b1;
    for (int c = 1; c <= 40 && ack_n < n_acks; c++) begin
      @(negedge clk);
      if (A_ack && ack_n < 8) begin
        ack_port[ack_n] = 0; ack_cyc[ack_n] = c; ack_n++;
        if (!hold) A_req = 1'b0;
      end
      if (B_ack && ack_n < 8) begin
        ack_port[ack_n] = 1; ack_cyc[ack_n] = c; ack_n++;
        if (!hold) B_req = 1'b0;
      end
    end
    A_req = 1'b0; B_req = 1'b0;
  endtask

  // scoreboard: transaction-level model of memory, info word and per-port read data
  logic [31:0] shadow [1024];
  logic [31:0] info_m;
  logic [31:0] last_rd [2];
  logic [31:0] exp_q [$];

  task automatic model_resp(input bit p, input bit we, input logic [21:0] addr,
                            input logic [31:0] wd);
    bit in_mem, own;
    int off;
    in_mem = (addr >= 22'h2000) && (addr <= 22'h23ff);
    own    = in_mem && (p ? (addr >= 22'h2200) : (addr < 22'h2200));
    off    = int'(addr) - 'h2000;
    if (we && own) begin
      shadow[off] = wd;
      exp_q.push_back(32'd0);
    end else if (!we && in_mem) begin
      last_rd[p] = shadow[off];
      exp_q.push_back(32'd0);
    end else if (!we && addr == 22'h2400) begin
      last_rd[p] = info_m;
      exp_q.push_back(32'd0);
    end else begin
      last_rd[p] = 32'h0;
      exp_q.push_back(32'd1);
    end
    exp_q.push_back(last_rd[p]);
  endtask

  typedef struct {
    bit          is_b;
    bit          we;
    logic [21:0] addr;
    logic [31:0] wd;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [19];
  int          lat;
  bit          err, saw_we, other_ack;
  logic [31:0] rd;
  logic [9:0]  we_addr;

  bit          pend [2];
  bit          t_we [2];
  logic [21:0] t_addr [2];
  logic [31:0] t_wd [2];
  int          age [2];

  initial begin
    vecs[0]  = '{0, 1, 22'h2005, 32'h12345678, 0, 32'h0};
    vecs[1]  = '{0, 0, 22'h2005, 32'h0,        0, 32'h12345678};
    vecs[2]  = '{0, 0, 22'h2400, 32'h0,        0, 32'hab};
    vecs[3]  = '{1, 0, 22'h2005, 32'h0,        0, 32'h12345678};
    vecs[4]  = '{1, 1, 22'h2210, 32'hcafef00d, 0, 32'h12345678};
    vecs[5]  = '{1, 1, 22'h2010, 32'hdeadbeef, 1, 32'h0};
    vecs[6]  = '{1, 0, 22'h2210, 32'h0,        0, 32'hcafef00d};
    vecs[7]  = '{0, 1, 22'h2210, 32'h11111111, 1, 32'h0};
    vecs[8]  = '{0, 1, 22'h2400, 32'h22222222, 1, 32'h0};
    vecs[9]  = '{0, 0, 22'h2400, 32'h0,        0, 32'hab};
    vecs[10] = '{0, 1, 22'h21ff, 32'h55555555, 0, 32'hab};
    vecs[11] = '{0, 0, 22'h21ff, 32'h0,        0, 32'h55555555};
    vecs[12] = '{1, 1, 22'h23ff, 32'h77777777, 0, 32'hcafef00d};
    vecs[13] = '{0, 0, 22'h23ff, 32'h0,        0, 32'h77777777};
    vecs[14] = '{1, 0, 22'h1fff, 32'h0,        1, 32'h0};
    vecs[15] = '{1, 0, 22'h3000, 32'h0,        1, 32'h0};
    vecs[16] = '{0, 1, 22'h2200, 32'h33333333, 1, 32'h0};
    vecs[17] = '{1, 0, 22'h2000, 32'h0,        0, 32'h0};
    vecs[18] = '{1, 0, 22'h2400, 32'h0,        0, 32'hab};

    rst = 1'b1; info_load = 1'b0; info_data = '0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);

    // reset values
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_ack", 32'({A_ack, B_ack}), 0);
    chk("rst_err", 32'({A_err, B_err}), 0);
    chk("rst_a_rd", A_read_data, 0);
    chk("rst_b_rd", B_read_data, 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;

    // single-transaction vector table
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      do_txn(vecs[i].is_b, vecs[i].we, vecs[i].addr, vecs[i].wd,
             lat, err, rd, saw_we, we_addr, other_ack);
      chk($sformatf("v%0d_latency", i), 32'(lat), 3);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_mem_we", i), 32'(saw_we), 32'(vecs[i].we && !vecs[i].exp_err));
      if (saw_we) chk($sformatf("v%0d_mem_addr", i), 32'(we_addr), 32'(vecs[i].addr[9:0]));
      chk($sformatf("v%0d_other_ack", i), 32'(other_ack), 0);
    end

    // collision after a B grant: A first, B three cycles later
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 22'h2005, '0);
    set_port(1, 1'b0, 1'b0, 22'h2210, '0);
    run_both(1'b0, 2);
    chk("col1_n", 32'(ack_n), 2);
    chk("col1_first", 32'(ack_port[0]), 0);
    chk("col1_first_cyc", 32'(ack_cyc[0]), 3);
    chk("col1_second", 32'(ack_port[1]), 1);
    chk("col1_second_cyc", 32'(ack_cyc[1]), 6);
    chk("col1_a_rd", A_read_data, 32'h12345678);
    chk("col1_b_rd", B_read_data, 32'hcafef00d);

    // after an A-only grant the next collision goes to B
    @(negedge clk);
    do_txn(0, 1'b0, 22'h2400, '0, lat, err, rd, saw_we, we_addr, other_ack);
    @(negedge clk);
    run_both(1'b0, 2);
    chk("col2_first", 32'(ack_port[0]), 1);
    chk("col2_first_cyc", 32'(ack_cyc[0]), 3);
    chk("col2_second", 32'(ack_port[1]), 0);
    chk("col2_second_cyc", 32'(ack_cyc[1]), 6);

    // A held high continuously with B requesting: strict alternation
    @(negedge clk);
    do_txn(1, 1'b0, 22'h2210, '0, lat, err, rd, saw_we, we_addr, other_ack);
    @(negedge clk);
    run_both(1'b1, 6);
    chk("fair_n", 32'(ack_n), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fair_port%0d", i), 32'(ack_port[i]), 32'(i % 2));
      chk($sformatf("fair_cyc%0d", i), 32'(ack_cyc[i]), 32'(3 * (i + 1)));
    end

    // info word load, then load coinciding with the RESP edge of an INFO_RD
    @(negedge clk);
    info_load = 1'b1; info_data = 32'hc0de;
    @(negedge clk);
    info_load = 1'b0;
    do_txn(1, 1'b0, 22'h2400, '0, lat, err, rd, saw_we, we_addr, other_ack);
    chk("info_new", rd, 32'hc0de);
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 22'h2400, '0);
    @(negedge clk);
    @(negedge clk);
    info_load = 1'b1; info_data = 32'hbeef;
    @(negedge clk);
    info_load = 1'b0;
    chk("info_coinc_ack", 32'(A_ack), 1);
    chk("info_coinc_old", A_read_data, 32'hc0de);
    set_port(0, 1'b0, 1'b0, 22'h2400, '0);
    @(negedge clk);
    do_txn(0, 1'b0, 22'h2400, '0, lat, err, rd, saw_we, we_addr, other_ack);
    chk("info_after", rd, 32'hbeef);

    // reset during ACCESS of an A write aborts it; held req re-arbitrates
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 22'h2040, 32'h99999999);
    @(negedge clk);
    chk("abort_we_before", 32'(mem_we), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_async", 32'(mem_we), 0);
    chk("abort_state", 32'(dbg_state), 0);
    @(negedge clk);
    chk("abort_no_ack", 32'(A_ack), 0);
    rst = 1'b0;
    lat = -1; err = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (A_ack) begin lat = i; err = A_err; rd = A_read_data; break; end
    end
    A_req = 1'b0;
    chk("abort_retry_lat", 32'(lat), 3);
    chk("abort_retry_err", 32'(err), 0);
    chk("abort_retry_rd", rd, 0);
    @(negedge clk);
    do_txn(0, 1'b0, 22'h2040, '0, lat, err, rd, saw_we, we_addr, other_ack);
    chk("abort_readback", rd, 32'h99999999);

    // randomized traffic on both CPUs against the model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (shadow[i]) shadow[i] = 32'h0;
    info_m = 32'hab;
    last_rd[0] = '0; last_rd[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      chk("rnd_dual_ack", 32'(A_ack & B_ack), 0);
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          age[p]++;
          if (p ? B_ack : A_ack) begin
            model_resp(p[0], t_we[p], t_addr[p], t_wd[p]);
            chk($sformatf("rnd_err_p%0d_%h", p, t_addr[p]), 32'(p ? B_err : A_err), exp_q.pop_front());
            chk($sformatf("rnd_rd_p%0d_%h", p, t_addr[p]), p ? B_read_data : A_read_data, exp_q.pop_front());
            pend[p] = 1'b0;
            set_port(p[0], 1'b0, t_we[p], t_addr[p], t_wd[p]);
          end else if (age[p] > 20) begin
            n_checks++; n_fail++;
            $display("FAIL rnd_timeout_p%0d: no ack after %0d cycles, required within 20", p, age[p]);
            pend[p] = 1'b0;
            set_port(p[0], 1'b0, t_we[p], t_addr[p], t_wd[p]);
          end
        end else if (cyc < 1470 && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3: t_addr[p] = 22'h2100 + 22'($urandom_range(0, 63));
            4, 5, 6, 7: t_addr[p] = 22'h2300 + 22'($urandom_range(0, 63));
            8:          t_addr[p] = 22'h2400;
            default:    t_addr[p] = ($urandom_range(0, 1) == 0) ? 22'h1fff : 22'h3000 + 22'($urandom_range(0, 15));
          endcase
          t_we[p] = $urandom_range(0, 1) == 1;
          t_wd[p] = $urandom;
          age[p]  = 0;
          pend[p] = 1'b1;
          set_port(p[0], 1'b1, t_we[p], t_addr[p], t_wd[p]);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
